// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types plus ID/EX latch state and register layout
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int SHAM_W = 4;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    IDEX_RUN    = 2'd0,
    IDEX_STALL  = 2'd1,
    IDEX_HALTED = 2'd2
  } idex_state_t;

  typedef struct packed {
    word_t             nPC;
    regbits_t          regDst;
    regbits_t          rs;
    regbits_t          rt;
    logic              dREN;
    logic              dWEN;
    logic              regWr;
    logic              halt;
    logic [2:0]        regSel;
    logic [2:0]        PCSrc;
    logic [2:0]        ALUSrc;
    aluop_t            ALUOp;
    word_t             rdat1;
    word_t             rdat2;
    word_t             imm;
    word_t             lui;
    logic [SHAM_W:0]   shamt;
  } idex_t;

  // All-zero is a harmless no-op: no writes, no memory access, sequential PC.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard compare between EX load and decoding instruction
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic     dren_ex_i,
  input  logic     regwr_ex_i,
  input  regbits_t regdst_ex_i,
  input  regbits_t rs_i,
  input  regbits_t rt_i,
  output logic     hazard_o
);

  // rt is compared even when the instruction does not read it; a spare stall is cheap.
  assign hazard_o = dren_ex_i & regwr_ex_i & (regdst_ex_i != '0) &
                    ((regdst_ex_i == rs_i) | (regdst_ex_i == rt_i));

endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX register with load-use stall, flush and halt; IDEX_PERF_EN adds counters
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int LOADUSE_BUBBLES = 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            en,
  input  logic            flush,
  input  word_t           nPC_next,
  input  regbits_t        regDst_next,
  input  regbits_t        rs_next,
  input  regbits_t        rt_next,
  input  logic            dREN_next,
  input  logic            dWEN_next,
  input  logic            regWr_next,
  input  logic            halt,
  input  logic [2:0]      regSel_next,
  input  logic [2:0]      PCSrc_next,
  input  logic [2:0]      ALUSrc_next,
  input  aluop_t          ALUOp_next,
  input  word_t           rdat1_next,
  input  word_t           rdat2_next,
  input  word_t           imm_next,
  input  word_t           lui_next,
  input  logic [SHAM_W:0] shamt_next,
  output word_t           nPC_ex,
  output regbits_t        regDst_ex,
  output regbits_t        rs_ex,
  output regbits_t        rt_ex,
  output logic            dREN_ex,
  output logic            dWEN_ex,
  output logic            regWr_ex,
  output logic            halt_ex,
  output logic [2:0]      regSel_ex,
  output logic [2:0]      PCSrc_ex,
  output logic [2:0]      ALUSrc_ex,
  output aluop_t          ALUOp_ex,
  output word_t           rdat1_ex,
  output word_t           rdat2_ex,
  output word_t           imm_ex,
  output word_t           lui_ex,
  output logic [SHAM_W:0] shamt_ex,
  output logic            stall_de,
`ifdef IDEX_PERF_EN
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            bubble_ex
);

  localparam logic [1:0] CNT_INIT = 2'(LOADUSE_BUBBLES - 1);

  idex_state_t state_q;
  logic [1:0]  cnt_q;
  idex_t       ex_q;
  logic        bubble_q;
  idex_t       in_w;
  logic        hazard;

  assign in_w = '{nPC: nPC_next, regDst: regDst_next, rs: rs_next, rt: rt_next,
                  dREN: dREN_next, dWEN: dWEN_next, regWr: regWr_next, halt: halt,
                  regSel: regSel_next, PCSrc: PCSrc_next, ALUSrc: ALUSrc_next,
                  ALUOp: ALUOp_next, rdat1: rdat1_next, rdat2: rdat2_next,
                  imm: imm_next, lui: lui_next, shamt: shamt_next};

  hazard_unit u_hazard (
    .dren_ex_i   (ex_q.dREN),
    .regwr_ex_i  (ex_q.regWr),
    .regdst_ex_i (ex_q.regDst),
    .rs_i        (rs_next),
    .rt_i        (rt_next),
    .hazard_o    (hazard)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDEX_RUN;
      cnt_q    <= '0;
      ex_q     <= IDEX_BUBBLE;
      bubble_q <= 1'b1;
    end else begin
      case (state_q)
        IDEX_HALTED: begin
          ex_q      <= IDEX_BUBBLE;
          ex_q.halt <= 1'b1;
          bubble_q  <= 1'b1;
        end
        IDEX_STALL: begin
          if (flush) begin
            ex_q     <= IDEX_BUBBLE;
            bubble_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDEX_RUN;
          end else if (en) begin
            ex_q     <= IDEX_BUBBLE;
            bubble_q <= 1'b1;
            cnt_q    <= cnt_q - 2'd1;
            // cnt_q counts bubbles still owed, including the one loaded now
            if (cnt_q == 2'd1) state_q <= IDEX_RUN;
          end
        end
        default: begin
          if (flush) begin
            ex_q     <= IDEX_BUBBLE;
            bubble_q <= 1'b1;
            state_q  <= IDEX_RUN;
          end else if (hazard && en) begin
            ex_q     <= IDEX_BUBBLE;
            bubble_q <= 1'b1;
            cnt_q    <= CNT_INIT;
            state_q  <= (CNT_INIT == 2'd0) ? IDEX_RUN : IDEX_STALL;
          end else if (en) begin
            ex_q     <= in_w;
            bubble_q <= 1'b0;
            if (halt) state_q <= IDEX_HALTED;
          end
        end
      endcase
    end
  end

  assign stall_de = ((state_q == IDEX_RUN) & hazard) |
                    (state_q == IDEX_STALL) | (state_q == IDEX_HALTED);

`ifdef IDEX_PERF_EN
  logic        hz_load, fl_load;
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  assign hz_load = ~flush & en &
                   (((state_q == IDEX_RUN) & hazard) | (state_q == IDEX_STALL));
  assign fl_load = flush & (state_q != IDEX_HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (hz_load) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (fl_load) flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

  assign nPC_ex    = ex_q.nPC;
  assign regDst_ex = ex_q.regDst;
  assign rs_ex     = ex_q.rs;
  assign rt_ex     = ex_q.rt;
  assign dREN_ex   = ex_q.dREN;
  assign dWEN_ex   = ex_q.dWEN;
  assign regWr_ex  = ex_q.regWr;
  assign halt_ex   = ex_q.halt;
  assign regSel_ex = ex_q.regSel;
  assign PCSrc_ex  = ex_q.PCSrc;
  assign ALUSrc_ex = ex_q.ALUSrc;
  assign ALUOp_ex  = ex_q.ALUOp;
  assign rdat1_ex  = ex_q.rdat1;
  assign rdat2_ex  = ex_q.rdat2;
  assign imm_ex    = ex_q.imm;
  assign lui_ex    = ex_q.lui;
  assign shamt_ex  = ex_q.shamt;
  assign bubble_ex = bubble_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// tb/tb_id_ex_latch.sv - scoreboard bench: three latches (1..3 bubbles) vs behavioural model
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  localparam int NI   = 3;
  localparam int NCYC = 3000;

  logic            CLK = 1'b0;
  logic            nRST, en, flush, halt;
  word_t           nPC_next, rdat1_next, rdat2_next, imm_next, lui_next;
  regbits_t        regDst_next, rs_next, rt_next;
  logic            dREN_next, dWEN_next, regWr_next;
  logic [2:0]      regSel_next, PCSrc_next, ALUSrc_next;
  aluop_t          ALUOp_next;
  logic [SHAM_W:0] shamt_next;

  idex_t       got_ex  [NI];
  logic        got_bub [NI];
  logic        got_st  [NI];
  logic [31:0] got_bc  [NI];
  logic [31:0] got_fc  [NI];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    word_t           o_npc, o_r1, o_r2, o_imm, o_lui;
    regbits_t        o_dst, o_rs, o_rt;
    logic            o_dren, o_dwen, o_rwr, o_halt;
    logic [2:0]      o_sel, o_pcs, o_alus;
    aluop_t          o_op;
    logic [SHAM_W:0] o_sh;
`ifdef IDEX_PERF_EN
    logic [31:0]     o_bc, o_fc;
    assign got_bc[g] = o_bc;
    assign got_fc[g] = o_fc;
`else
    assign got_bc[g] = '0;
    assign got_fc[g] = '0;
`endif
    id_ex_latch #(.LOADUSE_BUBBLES(g + 1)) u_dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .nPC_next(nPC_next), .regDst_next(regDst_next), .rs_next(rs_next),
      .rt_next(rt_next), .dREN_next(dREN_next), .dWEN_next(dWEN_next),
      .regWr_next(regWr_next), .halt(halt), .regSel_next(regSel_next),
      .PCSrc_next(PCSrc_next), .ALUSrc_next(ALUSrc_next), .ALUOp_next(ALUOp_next),
      .rdat1_next(rdat1_next), .rdat2_next(rdat2_next), .imm_next(imm_next),
      .lui_next(lui_next), .shamt_next(shamt_next),
      .nPC_ex(o_npc), .regDst_ex(o_dst), .rs_ex(o_rs), .rt_ex(o_rt),
      .dREN_ex(o_dren), .dWEN_ex(o_dwen), .regWr_ex(o_rwr), .halt_ex(o_halt),
      .regSel_ex(o_sel), .PCSrc_ex(o_pcs), .ALUSrc_ex(o_alus), .ALUOp_ex(o_op),
      .rdat1_ex(o_r1), .rdat2_ex(o_r2), .imm_ex(o_imm), .lui_ex(o_lui),
      .shamt_ex(o_sh), .stall_de(got_st[g]),
`ifdef IDEX_PERF_EN
      .bubble_cnt(o_bc), .flush_cnt(o_fc),
`endif
      .bubble_ex(got_bub[g])
    );
    assign got_ex[g] = '{nPC: o_npc, regDst: o_dst, rs: o_rs, rt: o_rt, dREN: o_dren,
                         dWEN: o_dwen, regWr: o_rwr, halt: o_halt, regSel: o_sel,
                         PCSrc: o_pcs, ALUSrc: o_alus, ALUOp: o_op, rdat1: o_r1,
                         rdat2: o_r2, imm: o_imm, lui: o_lui, shamt: o_sh};
  end

  typedef struct {
    idex_t       ex;
    logic        bub;
    logic [31:0] bc;
    logic [31:0] fc;
  } exp_t;

  exp_t q_ex [NI][$];
  logic q_st [NI][$];

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = flowing, 1 = owing bubbles, 2 = halted for good.
  int          m_mode [NI];
  int          m_owed [NI];
  idex_t       m_ex   [NI];
  logic        m_bub  [NI];
  logic [31:0] m_bc   [NI];
  logic [31:0] m_fc   [NI];

  function automatic logic load_use(idex_t e, regbits_t rs, regbits_t rt);
    return e.dREN && e.regWr && e.regDst != 0 && (e.regDst == rs || e.regDst == rt);
  endfunction

  task automatic model_reset(int k);
    m_mode[k] = 0; m_owed[k] = 0; m_ex[k] = '0; m_bub[k] = 1'b1;
    m_bc[k] = 0; m_fc[k] = 0;
  endtask

  task automatic model_step(int k, idex_t in_s, logic en_v, logic fl_v);
    logic lu;
    lu = load_use(m_ex[k], in_s.rs, in_s.rt);
    if (m_mode[k] == 2) begin
      m_ex[k] = '0; m_ex[k].halt = 1'b1; m_bub[k] = 1'b1;
    end else if (fl_v) begin
      m_ex[k] = '0; m_bub[k] = 1'b1; m_mode[k] = 0; m_owed[k] = 0; m_fc[k]++;
    end else if (m_mode[k] == 1) begin
      if (en_v) begin
        m_ex[k] = '0; m_bub[k] = 1'b1; m_bc[k]++; m_owed[k]--;
        if (m_owed[k] == 0) m_mode[k] = 0;
      end
    end else if (lu && en_v) begin
      m_ex[k] = '0; m_bub[k] = 1'b1; m_bc[k]++;
      m_owed[k] = k;                   // instance k inserts k+1 bubbles in total
      m_mode[k] = (m_owed[k] > 0) ? 1 : 0;
    end else if (en_v) begin
      m_ex[k] = in_s; m_bub[k] = 1'b0;
      if (in_s.halt) m_mode[k] = 2;
    end
  endtask

  function automatic exp_t snap(int k);
    exp_t e;
    e.ex = m_ex[k]; e.bub = m_bub[k];
`ifdef IDEX_PERF_EN
    e.bc = m_bc[k]; e.fc = m_fc[k];
`else
    e.bc = '0; e.fc = '0;
`endif
    return e;
  endfunction

  initial begin
    idex_t in_s;
    nRST = 1'b0; en = 1'b0; flush = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      in_s.nPC    = $urandom;
      in_s.regDst = regbits_t'($urandom_range(0, 3));
      in_s.rs     = regbits_t'($urandom_range(0, 3));
      in_s.rt     = regbits_t'($urandom_range(0, 3));
      in_s.dREN   = ($urandom_range(0, 1) == 0);
      in_s.dWEN   = ($urandom_range(0, 3) == 0);
      in_s.regWr  = ($urandom_range(0, 9) < 7);
      in_s.halt   = ($urandom_range(0, 99) == 0);
      in_s.regSel = 3'($urandom);
      in_s.PCSrc  = 3'($urandom);
      in_s.ALUSrc = 3'($urandom);
      in_s.ALUOp  = aluop_t'($urandom_range(0, 9));
      in_s.rdat1  = $urandom;
      in_s.rdat2  = $urandom;
      in_s.imm    = $urandom;
      in_s.lui    = $urandom;
      in_s.shamt  = (SHAM_W + 1)'($urandom);
      en    = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 99) < 8);
      nPC_next = in_s.nPC; regDst_next = in_s.regDst; rs_next = in_s.rs;
      rt_next = in_s.rt; dREN_next = in_s.dREN; dWEN_next = in_s.dWEN;
      regWr_next = in_s.regWr; halt = in_s.halt; regSel_next = in_s.regSel;
      PCSrc_next = in_s.PCSrc; ALUSrc_next = in_s.ALUSrc; ALUOp_next = in_s.ALUOp;
      rdat1_next = in_s.rdat1; rdat2_next = in_s.rdat2; imm_next = in_s.imm;
      lui_next = in_s.lui; shamt_next = in_s.shamt;
      if (c == 0 || $urandom_range(0, 59) == 0) begin
        nRST = 1'b0;
        for (int k = 0; k < NI; k++) begin
          model_reset(k);
          q_st[k].push_back(1'b0);
          q_ex[k].push_back(snap(k));
        end
      end else begin
        nRST = 1'b1;
        for (int k = 0; k < NI; k++) begin
          q_st[k].push_back((m_mode[k] == 0) ? load_use(m_ex[k], in_s.rs, in_s.rt) : 1'b1);
          model_step(k, in_s, en, flush);
          q_ex[k].push_back(snap(k));
        end
      end
    end
    @(posedge CLK);
    #3;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (q_ex[k].size() != 0 || q_st[k].size() != 0) begin
        failures++;
        $display("FAIL drain[LB=%0d] left ex=%0d stall=%0d required 0", k + 1,
                 q_ex[k].size(), q_st[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Combinational stall, sampled once inputs for the coming edge have settled.
  initial forever begin
    @(negedge CLK);
    #3;
    for (int k = 0; k < NI; k++) begin
      if (q_st[k].size() != 0) begin
        logic e;
        e = q_st[k].pop_front();
        checks++;
        if (got_st[k] !== e) begin
          failures++;
          $display("FAIL stall_de[LB=%0d] t=%0t got=%b required=%b", k + 1, $time, got_st[k], e);
        end
      end
    end
  end

  // Registered outputs, sampled just after the edge that loaded them.
  initial forever begin
    @(posedge CLK);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (q_ex[k].size() != 0) begin
        exp_t e;
        e = q_ex[k].pop_front();
        checks++;
        if (got_ex[k] !== e.ex || got_bub[k] !== e.bub ||
            got_bc[k] !== e.bc || got_fc[k] !== e.fc) begin
          failures++;
          $display("FAIL ex_regs[LB=%0d] t=%0t got=%h bub=%b bc=%0d fc=%0d required=%h bub=%b bc=%0d fc=%0d",
                   k + 1, $time, got_ex[k], got_bub[k], got_bc[k], got_fc[k],
                   e.ex, e.bub, e.bc, e.fc);
        end
      end
    end
  end

endmodule
